// File: rtl/tnn_feature_sequencer.sv
// Feature sequencer for the approximate TNN neuron: packs a stream of quantised
// features into the neuron operand bus, waits for the combinational neuron to
// settle, captures its decision and returns it over a valid/ready result stream.
module tnn_feature_sequencer #(
   parameter int unsigned LANES       = 5,
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned EVAL_CYCLES = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WIDTH-1:0]       s_data,
   input  logic                   s_last,
   output logic [LANES*WIDTH-1:0] vec,
   input  logic                   neuron_out,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_class,
   output logic                   m_error,
   output logic [CNT_W-1:0]       sample_cnt
);

   localparam int unsigned VEC_W    = LANES * WIDTH;
   localparam int unsigned IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned EC_W     = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
   localparam logic [EC_W-1:0]  EC_LAST  = EC_W'(EVAL_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_EVAL    = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic               err_q, err_d;
   logic [EC_W-1:0]    ecnt_q, ecnt_d;
   logic               s_ready_q, s_ready_d;
   logic               m_valid_q, m_valid_d;
   logic               m_class_q, m_class_d;
   logic               m_error_q, m_error_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept;

   assign accept     = s_valid && s_ready_q;
   assign s_ready    = s_ready_q;
   assign vec        = vec_q;
   assign m_valid    = m_valid_q;
   assign m_class    = m_class_q;
   assign m_error    = m_error_q;
   assign sample_cnt = cnt_q;

   // State and datapath registers; reset discards any partial sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         idx_q     <= '0;
         vec_q     <= '0;
         err_q     <= 1'b0;
         ecnt_q    <= '0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
         m_class_q <= 1'b0;
         m_error_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vec_q     <= vec_d;
         err_q     <= err_d;
         ecnt_q    <= ecnt_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_class_q <= m_class_d;
         m_error_q <= m_error_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and datapath update for collect / drain / evaluate / hold.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vec_d     = vec_q;
      err_d     = err_q;
      ecnt_d    = ecnt_q;
      m_valid_d = m_valid_q;
      m_class_d = m_class_q;
      m_error_d = m_error_q;
      cnt_d     = cnt_q;

      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               for (int unsigned l = 0; l < LANES; l++) begin
                  if (idx_q == IDX_W'(l)) begin
                     vec_d[l*WIDTH +: WIDTH] = s_data;
                  end
               end
               if (s_last) begin
                  // Short samples leave the remaining lanes at zero.
                  err_d   = (idx_q != LAST_IDX);
                  state_d = ST_EVAL;
               end else if (idx_q == LAST_IDX) begin
                  // Vector full but sample continues: swallow the excess.
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         ST_DRAIN: begin
            if (accept && s_last) begin
               state_d = ST_EVAL;
            end
         end

         ST_EVAL: begin
            if (ecnt_q == EC_LAST) begin
               ecnt_d    = '0;
               m_class_d = neuron_out;
               m_error_d = err_q;
               m_valid_d = 1'b1;
               state_d   = ST_HOLD;
            end else begin
               ecnt_d = ecnt_q + EC_W'(1);
            end
         end

         ST_HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               cnt_d     = cnt_q + CNT_W'(1);
               vec_d     = '0;
               idx_d     = '0;
               err_d     = 1'b0;
               state_d   = ST_COLLECT;
            end
         end

         default: begin
            state_d = ST_COLLECT;
         end
      endcase

      s_ready_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
   end

endmodule
